// File: rtl/decoder_scan.sv
// decoder_scan: registered one-hot/thermometer decoder with a direct mode and a prescaled auto-scan mode
module decoder_scan #(
    parameter int IN_W    = 5,
    parameter int OUT_N   = 2**IN_W,
    parameter int DIV     = 4,
    parameter bit ACT_LOW = 1'b0,
    parameter bit THERMO  = 1'b0
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iEna,
    input  logic             iScan,
    input  logic [IN_W-1:0]  iData,
    output logic [OUT_N-1:0] oData,
    output logic [IN_W-1:0]  oIndex,
    output logic             oValid,
    output logic             oWrap,
    output logic             oErr
);
    localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [OUT_N-1:0] INACTIVE = {OUT_N{ACT_LOW}};

    typedef enum logic {DIRECT, SCAN} modeE;

    modeE            mode, modeNext;
    logic [IN_W-1:0] scanIdx, scanIdxNext, indexNext;
    logic [PW-1:0]   pre, preNext;
    logic [OUT_N-1:0] dataNext;
    logic            validNext, wrapNext, errNext;
    logic            preLast, idxLast, inRange;

    function automatic logic [OUT_N-1:0] enc(input logic [IN_W-1:0] n);
        logic [OUT_N-1:0] v;
        for (int k = 0; k < OUT_N; k++)
            v[k] = THERMO ? (32'(k) <= 32'(n)) : (32'(k) == 32'(n));
        return v ^ INACTIVE;
    endfunction

    assign preLast = 32'(pre) == 32'(DIV - 1);
    assign idxLast = 32'(scanIdx) == 32'(OUT_N - 1);
    assign inRange = 32'(iData) < 32'(OUT_N);

    always_comb begin
        modeNext    = mode;
        scanIdxNext = scanIdx;
        preNext     = pre;
        dataNext    = INACTIVE;
        indexNext   = oIndex;
        validNext   = 1'b0;
        wrapNext    = 1'b0;
        errNext     = 1'b0;
        if (!iScan) begin
            modeNext    = DIRECT;
            scanIdxNext = '0;
            preNext     = '0;
            if (iEna) begin
                errNext   = !inRange;
                validNext = inRange;
                dataNext  = inRange ? enc(iData) : INACTIVE;
                indexNext = inRange ? iData : oIndex;
            end
        end else if (iEna) begin
            // first enabled scan cycle reloads so index 0 is shown for a full DIV clocks
            if (mode == DIRECT) begin
                modeNext    = SCAN;
                scanIdxNext = '0;
                preNext     = '0;
            end else if (preLast) begin
                preNext     = '0;
                wrapNext    = idxLast;
                scanIdxNext = idxLast ? '0 : scanIdx + 1'b1;
            end else begin
                preNext = pre + 1'b1;
            end
            dataNext  = enc(scanIdxNext);
            indexNext = scanIdxNext;
            validNext = 1'b1;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            mode    <= DIRECT;
            scanIdx <= '0;
            pre     <= '0;
            oData   <= INACTIVE;
            oIndex  <= '0;
            oValid  <= 1'b0;
            oWrap   <= 1'b0;
            oErr    <= 1'b0;
        end else begin
            mode    <= modeNext;
            scanIdx <= scanIdxNext;
            pre     <= preNext;
            oData   <= dataNext;
            oIndex  <= indexNext;
            oValid  <= validNext;
            oWrap   <= wrapNext;
            oErr    <= errNext;
        end
    end
endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: table-driven direct-mode vectors plus hand-written scan, freeze and reset sequences
module tb_decoder_scan;
    logic       clk = 1'b0;
    logic       rst, ena, scan;
    logic [2:0] data;
    logic [5:0] oData, altData;
    logic [2:0] oIndex, altIndex;
    logic       oValid, oWrap, oErr, altValid, altWrap, altErr;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    decoder_scan #(.IN_W(3), .OUT_N(6), .DIV(3), .ACT_LOW(1'b0), .THERMO(1'b0)) dut (
        .iClk(clk), .iRst(rst), .iEna(ena), .iScan(scan), .iData(data),
        .oData(oData), .oIndex(oIndex), .oValid(oValid), .oWrap(oWrap), .oErr(oErr)
    );

    decoder_scan #(.IN_W(3), .OUT_N(6), .DIV(3), .ACT_LOW(1'b1), .THERMO(1'b1)) alt (
        .iClk(clk), .iRst(rst), .iEna(ena), .iScan(scan), .iData(data),
        .oData(altData), .oIndex(altIndex), .oValid(altValid), .oWrap(altWrap), .oErr(altErr)
    );

    typedef struct {
        logic       rst, ena, scan;
        logic [2:0] data;
        logic [5:0] expData;
        logic [2:0] expIdx;
        logic       expValid, expErr;
        logic [5:0] expAlt;
    } vecT;

    vecT vecs[12];

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic s, input logic [2:0] d);
        rst = r; ena = e; scan = s; data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkMain(input string name, input logic [5:0] d, input logic [2:0] idx,
                             input logic v, input logic w, input logic e);
        cmp({name, ".data"}, 32'(oData), 32'(d));
        cmp({name, ".index"}, 32'(oIndex), 32'(idx));
        cmp({name, ".valid"}, 32'(oValid), 32'(v));
        cmp({name, ".wrap"}, 32'(oWrap), 32'(w));
        cmp({name, ".err"}, 32'(oErr), 32'(e));
    endtask

    initial begin
        vecs[0]  = '{1, 1, 1, 3'd0, 6'b000000, 3'd0, 0, 0, 6'b111111};
        vecs[1]  = '{1, 1, 1, 3'd0, 6'b000000, 3'd0, 0, 0, 6'b111111};
        vecs[2]  = '{0, 1, 0, 3'd0, 6'b000001, 3'd0, 1, 0, 6'b111110};
        vecs[3]  = '{0, 1, 0, 3'd1, 6'b000010, 3'd1, 1, 0, 6'b111100};
        vecs[4]  = '{0, 1, 0, 3'd2, 6'b000100, 3'd2, 1, 0, 6'b111000};
        vecs[5]  = '{0, 1, 0, 3'd3, 6'b001000, 3'd3, 1, 0, 6'b110000};
        vecs[6]  = '{0, 1, 0, 3'd4, 6'b010000, 3'd4, 1, 0, 6'b100000};
        vecs[7]  = '{0, 1, 0, 3'd5, 6'b100000, 3'd5, 1, 0, 6'b000000};
        vecs[8]  = '{0, 1, 0, 3'd6, 6'b000000, 3'd5, 0, 1, 6'b111111};
        vecs[9]  = '{0, 1, 0, 3'd7, 6'b000000, 3'd5, 0, 1, 6'b111111};
        vecs[10] = '{0, 0, 0, 3'd3, 6'b000000, 3'd5, 0, 0, 6'b111111};
        vecs[11] = '{0, 1, 0, 3'd2, 6'b000100, 3'd2, 1, 0, 6'b111000};

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].rst, vecs[i].ena, vecs[i].scan, vecs[i].data);
            checkMain($sformatf("vec%0d", i), vecs[i].expData, vecs[i].expIdx,
                      vecs[i].expValid, 1'b0, vecs[i].expErr);
            cmp($sformatf("vec%0d.alt", i), 32'(altData), 32'(vecs[i].expAlt));
        end

        // scan from entry: each index held 3 clocks, wrap on edge 18; ends at index 2 with prescaler 1
        for (int k = 0; k < 26; k++) begin
            int idx;
            idx = (k / 3) % 6;
            step(0, 1, 1, 3'd7);
            checkMain($sformatf("scan%0d", k), 6'(1 << idx), 3'(idx), 1'b1, k == 18, 1'b0);
        end

        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, 3'd0);
            checkMain($sformatf("freeze%0d", k), 6'b000000, 3'd2, 1'b0, 1'b0, 1'b0);
        end
        step(0, 1, 1, 3'd0);
        checkMain("resume2", 6'b000100, 3'd2, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 1, 3'd0);
            checkMain($sformatf("resume3_%0d", k), 6'b001000, 3'd3, 1'b1, 1'b0, 1'b0);
        end
        step(0, 1, 1, 3'd0);
        checkMain("scan4", 6'b010000, 3'd4, 1'b1, 1'b0, 1'b0);

        step(1, 1, 1, 3'd0);
        checkMain("midReset", 6'b000000, 3'd0, 1'b0, 1'b0, 1'b0);
        cmp("midReset.alt", 32'(altData), 32'(6'b111111));
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 1, 3'd0);
            checkMain($sformatf("restart%0d", k), 6'b000001, 3'd0, 1'b1, 1'b0, 1'b0);
        end
        step(0, 1, 1, 3'd0);
        checkMain("restart1", 6'b000010, 3'd1, 1'b1, 1'b0, 1'b0);

        step(0, 1, 0, 3'd4);
        checkMain("toDirect", 6'b010000, 3'd4, 1'b1, 1'b0, 1'b0);
        step(0, 1, 1, 3'd5);
        checkMain("reEntry", 6'b000001, 3'd0, 1'b1, 1'b0, 1'b0);
        cmp("reEntry.alt", 32'(altData), 32'(6'b111110));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
